// File: rtl/dm_arb_pkg.sv
// Shared widths, port indices and counter width for the data-memory arbiter.
package dm_arb_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int P_PIPE = 0;
    localparam int P_AUX  = 1;
    localparam int CNT_W  = 4;
endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side and memory-side pins of the data-memory arbiter.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = dm_arb_pkg::ADDR_W,
    parameter int DW = dm_arb_pkg::DATA_W
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          stall0;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_dataw;
    logic [DW-1:0] dm_data;
    logic          dm_read;
    logic          dm_write;

    // Requesters plus the memory itself sit on the master side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
        input  dm_addr, dm_dataw, dm_read, dm_write
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
        output dm_addr, dm_dataw, dm_read, dm_write
    );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Counts consecutive denied cycles of the secondary port and flags a forced grant.
// Latency: flag is registered state, visible in the cycle after the limit is reached.
// Backpressure: none; clears whenever the port is granted or stops requesting.
module dm_arb_starve_cnt
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic force_win
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_win = (wait_cnt >= LIMIT);
endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage and an auxiliary master.
// Latency: grant and memory pins same cycle; read data registered, valid one cycle later.
// Backpressure: pipeline port is stalled whenever it requests and loses arbitration.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = dm_arb_pkg::ADDR_W,
    parameter int DATA_W       = dm_arb_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        gnt;
    logic [1:0]        rd_hit;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata [2];
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_dataw;
    logic              mux_we;
    logic              force1;

    assign req[P_PIPE] = bus.req0;
    assign req[P_AUX]  = bus.req1;
    assign we[P_PIPE]  = bus.we0;
    assign we[P_AUX]   = bus.we1;

    dm_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .req       (req[P_AUX]),
        .gnt       (gnt[P_AUX]),
        .force_win (force1)
    );

    // Pipeline has fixed priority unless the auxiliary port has starved long enough.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (force1 && req[P_AUX]) begin
                gnt[P_AUX] = 1'b1;
            end else if (req[P_PIPE]) begin
                gnt[P_PIPE] = 1'b1;
            end else if (req[P_AUX]) begin
                gnt[P_AUX] = 1'b1;
            end
        end
    end

    always_comb begin
        mux_addr  = '0;
        mux_dataw = '0;
        mux_we    = 1'b0;
        if (gnt[P_PIPE]) begin
            mux_addr  = bus.addr0;
            mux_dataw = bus.wdata0;
            mux_we    = bus.we0;
        end else if (gnt[P_AUX]) begin
            mux_addr  = bus.addr1;
            mux_dataw = bus.wdata1;
            mux_we    = bus.we1;
        end
    end

    assign rd_hit = gnt & ~we;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '{default: '0};
        end else begin
            rvalid <= rd_hit;
            for (int p = 0; p < 2; p++) begin
                if (rd_hit[p]) begin
                    rdata[p] <= bus.dm_data;
                end
            end
        end
    end

    assign bus.gnt0     = gnt[P_PIPE];
    assign bus.gnt1     = gnt[P_AUX];
    assign bus.stall0   = req[P_PIPE] & ~gnt[P_PIPE];
    assign bus.rvalid0  = rvalid[P_PIPE];
    assign bus.rvalid1  = rvalid[P_AUX];
    assign bus.rdata0   = rdata[P_PIPE];
    assign bus.rdata1   = rdata[P_AUX];
    assign bus.dm_addr  = mux_addr;
    assign bus.dm_dataw = mux_dataw;
    assign bus.dm_read  = (|gnt) & ~mux_we;
    assign bus.dm_write = (|gnt) & mux_we;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 256x16 memory on the memory pins.
module tb_dm_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dm_arbiter_if #(.AW(8), .DW(16)) bus ();

    dm_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (16),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (bus.dm_write) mem[bus.dm_addr] <= bus.dm_dataw;
    end
    assign bus.dm_data = bus.dm_read ? mem[bus.dm_addr] : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; combinational outputs are sampled 1 ns later.
    task automatic step(input logic r,
                        input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        @(negedge clk);
        rst        = r;
        bus.req0   = r0;
        bus.we0    = w0;
        bus.addr0  = a0;
        bus.wdata0 = d0;
        bus.req1   = r1;
        bus.we1    = w1;
        bus.addr1  = a1;
        bus.wdata1 = d1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h01] = 16'h000A;
        mem[8'h02] = 16'h000B;
        mem[8'h03] = 16'h000C;
        mem[8'hFF] = 16'hBEEF;
        rst        = 1'b1;
        bus.req0   = 1'b1;
        bus.req1   = 1'b1;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = 8'h05;
        bus.addr1  = 8'hFF;
        bus.wdata0 = '0;
        bus.wdata1 = '0;

        // Reset held two cycles with both ports requesting.
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 0, 8'h05, 16'h0, 1, 0, 8'hFF, 16'h0);
            chk("rst_gnt0", bus.gnt0, 0);
            chk("rst_gnt1", bus.gnt1, 0);
            chk("rst_dm_read", bus.dm_read, 0);
            chk("rst_dm_write", bus.dm_write, 0);
            chk("rst_stall0", bus.stall0, 1);
            chk("rst_rvalid0", bus.rvalid0, 0);
            chk("rst_rvalid1", bus.rvalid1, 0);
            chk("rst_rdata0", bus.rdata0, 16'h0);
            chk("rst_rdata1", bus.rdata1, 16'h0);
        end

        // Port 0 write then read back.
        step(0, 1, 1, 8'h05, 16'h1234, 0, 0, 8'h00, 16'h0);
        chk("wr_gnt0", bus.gnt0, 1);
        chk("wr_gnt1", bus.gnt1, 0);
        chk("wr_dm_write", bus.dm_write, 1);
        chk("wr_dm_read", bus.dm_read, 0);
        chk("wr_dm_addr", bus.dm_addr, 8'h05);
        chk("wr_dm_dataw", bus.dm_dataw, 16'h1234);
        chk("wr_stall0", bus.stall0, 0);
        chk("wr_rvalid0", bus.rvalid0, 0);
        step(0, 1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("rd_gnt0", bus.gnt0, 1);
        chk("rd_dm_read", bus.dm_read, 1);
        chk("rd_dm_write", bus.dm_write, 0);
        chk("rd_rvalid0_after_wr", bus.rvalid0, 0);
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("rd_rvalid0", bus.rvalid0, 1);
        chk("rd_rdata0", bus.rdata0, 16'h1234);
        chk("idle_gnt0", bus.gnt0, 0);
        chk("idle_dm_read", bus.dm_read, 0);
        chk("idle_dm_addr", bus.dm_addr, 8'h00);

        // Port 1 read alone, granted immediately.
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'hFF, 16'h0);
        chk("p1_rvalid0_drop", bus.rvalid0, 0);
        chk("p1_rdata0_hold", bus.rdata0, 16'h1234);
        chk("p1_gnt1", bus.gnt1, 1);
        chk("p1_gnt0", bus.gnt0, 0);
        chk("p1_dm_addr", bus.dm_addr, 8'hFF);
        chk("p1_dm_read", bus.dm_read, 1);
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("p1_rvalid1", bus.rvalid1, 1);
        chk("p1_rdata1", bus.rdata1, 16'hBEEF);
        chk("p1_rvalid0", bus.rvalid0, 0);

        // Six cycles of contention: port 1 forced in on its fifth requesting cycle.
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 0, 8'h03, 16'h0, 1, 0, 8'h05, 16'h0);
            chk($sformatf("cont%0d_gnt0", k), bus.gnt0, (k != 5));
            chk($sformatf("cont%0d_gnt1", k), bus.gnt1, (k == 5));
            chk($sformatf("cont%0d_stall0", k), bus.stall0, (k == 5));
            chk($sformatf("cont%0d_dm_addr", k), bus.dm_addr, (k == 5) ? 8'h05 : 8'h03);
            if (k == 6) begin
                chk("cont_rvalid1", bus.rvalid1, 1);
                chk("cont_rdata1", bus.rdata1, 16'h1234);
            end
        end
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("cont_end_rvalid1", bus.rvalid1, 0);
        chk("cont_end_rvalid0", bus.rvalid0, 1);
        chk("cont_end_rdata0", bus.rdata0, 16'h000C);

        // Back-to-back port 0 reads.
        step(0, 1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0);
        step(0, 1, 0, 8'h02, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("b2b1_rvalid0", bus.rvalid0, 1);
        chk("b2b1_rdata0", bus.rdata0, 16'h000A);
        step(0, 1, 0, 8'h03, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("b2b2_rvalid0", bus.rvalid0, 1);
        chk("b2b2_rdata0", bus.rdata0, 16'h000B);
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("b2b3_rvalid0", bus.rvalid0, 1);
        chk("b2b3_rdata0", bus.rdata0, 16'h000C);
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("b2b_end_rvalid0", bus.rvalid0, 0);

        // Build up starvation, then reset during a port-1 read.
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 8'h01, 16'h0, 1, 0, 8'hFF, 16'h0);
            chk($sformatf("pre%0d_gnt1", k), bus.gnt1, 0);
        end
        step(1, 0, 0, 8'h00, 16'h0, 1, 0, 8'hFF, 16'h0);
        chk("mid_rst_gnt1", bus.gnt1, 0);
        chk("mid_rst_dm_read", bus.dm_read, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 0, 8'h02, 16'h0, 1, 0, 8'hFF, 16'h0);
            if (k == 1) begin
                chk("post_rst_rvalid1", bus.rvalid1, 0);
                chk("post_rst_rdata1", bus.rdata1, 16'h0);
                chk("post_rst_rdata0", bus.rdata0, 16'h0);
            end
            chk($sformatf("post%0d_gnt1", k), bus.gnt1, (k == 5));
            chk($sformatf("post%0d_gnt0", k), bus.gnt0, (k != 5));
        end
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("post_rvalid1", bus.rvalid1, 1);
        chk("post_rdata1", bus.rdata1, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
